param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/param_updown_counter.sv | 89 ++++++++
 tb/tb_param_updown_counter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with clear, checked parallel load, and
// wrap/overflow/load-error status flags. Bounds either wrap or saturate.
module param_updown_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             ovf,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             load_err_q, load_err_d;
  logic             bound_hit;
  logic             load_ok;

  // MODULUS may be 2**32, so compare in 64 bits.
  assign load_ok = (64'(load_val) < MODULUS);

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    bound_hit  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) begin
        count_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (count_q == MaxVal) begin
          bound_hit = 1'b1;
          if (!SATURATE) count_d = '0;
        end else begin
          count_d = count_q + One;
        end
      end else begin
        if (count_q == '0) begin
          bound_hit = 1'b1;
          if (!SATURATE) count_d = MaxVal;
        end else begin
          count_d = count_q - One;
        end
      end
    end
    wrap_d = bound_hit;
    // A bound event wins over a simultaneous clear request.
    ovf_d  = (ovf_q & ~ovf_clr) | bound_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = count_q;
  assign wrap     = wrap_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: a wrapping (MODULUS=10) and a saturating
// instance share all inputs; expectations go through per-instance scoreboards.
module tb_param_updown_counter;

  typedef struct packed {
    logic       rst_n;
    logic       clr;
    logic       load;
    logic [3:0] lv;
    logic       en;
    logic       up;
    logic       oc;
  } stim_t;

  typedef struct packed {
    logic [3:0] q;
    logic       w;
    logic       o;
    logic       le;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       ovf_clr = 1'b0;

  logic [3:0] q_n, q_s;
  logic       wrap_n, wrap_s, ovf_n, ovf_s, load_err_n, load_err_s;

  int checks = 0;
  int errors = 0;

  obs_t exp_n[$];
  obs_t exp_s[$];

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .ovf_clr(ovf_clr), .q(q_n), .wrap(wrap_n), .ovf(ovf_n),
    .load_err(load_err_n)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .ovf_clr(ovf_clr), .q(q_s), .wrap(wrap_s), .ovf(ovf_s),
    .load_err(load_err_s)
  );

  function automatic stim_t st(input logic r, input logic c, input logic l,
                               input logic [3:0] lv, input logic e, input logic u,
                               input logic oc);
    return '{rst_n: r, clr: c, load: l, lv: lv, en: e, up: u, oc: oc};
  endfunction

  function automatic obs_t ob(input logic [3:0] qv, input logic w, input logic o,
                              input logic le);
    return '{q: qv, w: w, o: o, le: le};
  endfunction

  // Drive one cycle of stimulus, queue its expected outcome, sample #1 after the edge.
  task automatic drive(input stim_t s, input obs_t en_exp, input obs_t es_exp);
    rst_n    = s.rst_n;
    clr      = s.clr;
    load     = s.load;
    load_val = s.lv;
    en       = s.en;
    up_dn    = s.up;
    ovf_clr  = s.oc;
    exp_n.push_back(en_exp);
    exp_s.push_back(es_exp);
    @(posedge clk);
    #1;
    rst_n = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, g;
    drive(st(0, 1, 1, 4'd7, 1, 1, 1), ob(0, 0, 0, 0), ob(0, 0, 0, 0));
    e = exp_n.pop_front(); g = {q_n, wrap_n, ovf_n, load_err_n}; checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL reset wrap_inst: got %h expected %h", g, e);
    end
    e = exp_s.pop_front(); g = {q_s, wrap_s, ovf_s, load_err_s}; checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL reset sat_inst: got %h expected %h", g, e);
    end
  endtask

  task automatic test_count_up();
    obs_t e, g;
    for (int i = 1; i <= 12; i++) begin
      drive(st(1, 0, 0, 4'd0, 1, 1, 0),
            ob(4'(i % 10), i == 10, i >= 10, 0),
            ob(4'((i > 9) ? 9 : i), i >= 10, i >= 10, 0));
      e = exp_n.pop_front(); g = {q_n, wrap_n, ovf_n, load_err_n}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL count_up[%0d] wrap_inst: got %h expected %h", i, g, e);
      end
      e = exp_s.pop_front(); g = {q_s, wrap_s, ovf_s, load_err_s}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL count_up[%0d] sat_inst: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_load_down();
    stim_t s[$];
    obs_t  rn[$], rs[$];
    obs_t  e, g;
    s.push_back(st(1, 0, 1, 4'd3, 0, 0, 1)); rn.push_back(ob(3, 0, 0, 0)); rs.push_back(ob(3, 0, 0, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 0, 0)); rn.push_back(ob(2, 0, 0, 0)); rs.push_back(ob(2, 0, 0, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 0, 0)); rn.push_back(ob(1, 0, 0, 0)); rs.push_back(ob(1, 0, 0, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 0, 0)); rn.push_back(ob(0, 0, 0, 0)); rs.push_back(ob(0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 0, 0)); rn.push_back(ob(9, 1, 1, 0)); rs.push_back(ob(0, 1, 1, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 0, 0)); rn.push_back(ob(8, 0, 1, 0)); rs.push_back(ob(0, 1, 1, 0));
    foreach (s[i]) begin
      drive(s[i], rn[i], rs[i]);
      e = exp_n.pop_front(); g = {q_n, wrap_n, ovf_n, load_err_n}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL load_down[%0d] wrap_inst: got %h expected %h", i, g, e);
      end
      e = exp_s.pop_front(); g = {q_s, wrap_s, ovf_s, load_err_s}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL load_down[%0d] sat_inst: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_load_err();
    stim_t s[$];
    obs_t  r[$];
    obs_t  e, g;
    s.push_back(st(1, 0, 1, 4'd5, 0, 0, 0));  r.push_back(ob(5, 0, 1, 0));
    s.push_back(st(1, 0, 1, 4'd12, 0, 0, 0)); r.push_back(ob(5, 0, 1, 1));
    s.push_back(st(1, 0, 1, 4'd7, 0, 0, 0));  r.push_back(ob(7, 0, 1, 0));
    s.push_back(st(1, 0, 0, 4'd0, 0, 0, 0));  r.push_back(ob(7, 0, 1, 0));
    s.push_back(st(1, 0, 1, 4'd9, 0, 0, 0));  r.push_back(ob(9, 0, 1, 0));
    s.push_back(st(1, 0, 1, 4'd10, 0, 0, 0)); r.push_back(ob(9, 0, 1, 1));
    // Rejected load still blocks the enabled count at the upper bound.
    s.push_back(st(1, 0, 1, 4'd15, 1, 1, 0)); r.push_back(ob(9, 0, 1, 1));
    s.push_back(st(1, 0, 0, 4'd0, 0, 0, 0));  r.push_back(ob(9, 0, 1, 0));
    foreach (s[i]) begin
      drive(s[i], r[i], r[i]);
      e = exp_n.pop_front(); g = {q_n, wrap_n, ovf_n, load_err_n}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL load_err[%0d] wrap_inst: got %h expected %h", i, g, e);
      end
      e = exp_s.pop_front(); g = {q_s, wrap_s, ovf_s, load_err_s}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL load_err[%0d] sat_inst: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_saturate();
    stim_t s[$];
    obs_t  rn[$], rs[$];
    obs_t  e, g;
    s.push_back(st(1, 0, 1, 4'd9, 0, 0, 1)); rn.push_back(ob(9, 0, 0, 0)); rs.push_back(ob(9, 0, 0, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 1, 0)); rn.push_back(ob(0, 1, 1, 0)); rs.push_back(ob(9, 1, 1, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 1, 0)); rn.push_back(ob(1, 0, 1, 0)); rs.push_back(ob(9, 1, 1, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 1, 0)); rn.push_back(ob(2, 0, 1, 0)); rs.push_back(ob(9, 1, 1, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 0, 0)); rn.push_back(ob(1, 0, 1, 0)); rs.push_back(ob(8, 0, 1, 0));
    s.push_back(st(1, 0, 1, 4'd0, 0, 0, 0)); rn.push_back(ob(0, 0, 1, 0)); rs.push_back(ob(0, 0, 1, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 0, 0)); rn.push_back(ob(9, 1, 1, 0)); rs.push_back(ob(0, 1, 1, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 0, 0)); rn.push_back(ob(8, 0, 1, 0)); rs.push_back(ob(0, 1, 1, 0));
    foreach (s[i]) begin
      drive(s[i], rn[i], rs[i]);
      e = exp_n.pop_front(); g = {q_n, wrap_n, ovf_n, load_err_n}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL saturate[%0d] wrap_inst: got %h expected %h", i, g, e);
      end
      e = exp_s.pop_front(); g = {q_s, wrap_s, ovf_s, load_err_s}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL saturate[%0d] sat_inst: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_priority();
    stim_t s[$];
    obs_t  rn[$], rs[$];
    obs_t  e, g;
    s.push_back(st(1, 0, 1, 4'd6, 0, 0, 0));  rn.push_back(ob(6, 0, 1, 0)); rs.push_back(ob(6, 0, 1, 0));
    s.push_back(st(1, 1, 1, 4'd4, 1, 1, 0));  rn.push_back(ob(0, 0, 1, 0)); rs.push_back(ob(0, 0, 1, 0));
    s.push_back(st(1, 1, 1, 4'd12, 0, 0, 0)); rn.push_back(ob(0, 0, 1, 0)); rs.push_back(ob(0, 0, 1, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 0, 1));  rn.push_back(ob(9, 1, 1, 0)); rs.push_back(ob(0, 1, 1, 0));
    s.push_back(st(1, 0, 0, 4'd0, 0, 0, 1));  rn.push_back(ob(9, 0, 0, 0)); rs.push_back(ob(0, 0, 0, 0));
    s.push_back(st(1, 0, 1, 4'd2, 1, 1, 0));  rn.push_back(ob(2, 0, 0, 0)); rs.push_back(ob(2, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i], rn[i], rs[i]);
      e = exp_n.pop_front(); g = {q_n, wrap_n, ovf_n, load_err_n}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL priority[%0d] wrap_inst: got %h expected %h", i, g, e);
      end
      e = exp_s.pop_front(); g = {q_s, wrap_s, ovf_s, load_err_s}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL priority[%0d] sat_inst: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_reset_midcount();
    stim_t s[$];
    obs_t  rn[$], rs[$];
    obs_t  e, g;
    s.push_back(st(1, 0, 1, 4'd9, 0, 0, 0)); rn.push_back(ob(9, 0, 0, 0)); rs.push_back(ob(9, 0, 0, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 1, 0)); rn.push_back(ob(0, 1, 1, 0)); rs.push_back(ob(9, 1, 1, 0));
    s.push_back(st(1, 0, 1, 4'd5, 0, 0, 0)); rn.push_back(ob(5, 0, 1, 0)); rs.push_back(ob(5, 0, 1, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 1, 0)); rn.push_back(ob(6, 0, 1, 0)); rs.push_back(ob(6, 0, 1, 0));
    s.push_back(st(0, 0, 1, 4'd3, 1, 1, 0)); rn.push_back(ob(0, 0, 0, 0)); rs.push_back(ob(0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 1, 0)); rn.push_back(ob(1, 0, 0, 0)); rs.push_back(ob(1, 0, 0, 0));
    s.push_back(st(1, 0, 0, 4'd0, 1, 1, 0)); rn.push_back(ob(2, 0, 0, 0)); rs.push_back(ob(2, 0, 0, 0));
    foreach (s[i]) begin
      drive(s[i], rn[i], rs[i]);
      e = exp_n.pop_front(); g = {q_n, wrap_n, ovf_n, load_err_n}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_midcount[%0d] wrap_inst: got %h expected %h", i, g, e);
      end
      e = exp_s.pop_front(); g = {q_s, wrap_s, ovf_s, load_err_s}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_midcount[%0d] sat_inst: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_direction_change();
    logic [3:0] exp_vals [6] = '{4'd3, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1};
    logic       ens [6]      = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       ups [6]      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    obs_t       e, g;
    for (int i = 0; i < 6; i++) begin
      drive(st(1, 0, 0, 4'd0, ens[i], ups[i], 0), ob(exp_vals[i], 0, 0, 0),
            ob(exp_vals[i], 0, 0, 0));
      e = exp_n.pop_front(); g = {q_n, wrap_n, ovf_n, load_err_n}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL direction[%0d] wrap_inst: got %h expected %h", i, g, e);
      end
      e = exp_s.pop_front(); g = {q_s, wrap_s, ovf_s, load_err_s}; checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL direction[%0d] sat_inst: got %h expected %h", i, g, e);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_count_up();
    test_load_down();
    test_load_err();
    test_saturate();
    test_priority();
    test_reset_midcount();
    test_direction_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
